// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared types and elaboration helpers for cla_seq_adder
//   state_e    : controller states IDLE / RUN / DONE
//   clog2_f    : ceiling log2 of a positive integer
//   chunks_f   : number of N-bit chunks in a W-bit operand
//   idx_w_f    : chunk index width, never less than 1 bit
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int chunks_f(input int w, input int n);
    return w / n;
  endfunction

  // A single-chunk build still needs a 1-bit index register.
  function automatic int idx_w_f(input int w, input int n);
    int r;
    r = clog2_f(chunks_f(w, n));
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cla_nbits.sv
// rtl/cla_nbits.sv - n-bit carry-lookahead adder slice (combinational)
//   a, b : n-bit addends
//   cin  : carry into bit 0
//   s    : n-bit sum
//   cout : carry out of bit n-1
module cla_nbits #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] s,
  output logic         cout
);

  logic [n-1:0] g;
  logic [n-1:0] p;
  logic [n:0]   c;

  // Each carry is formed directly from generate/propagate terms and cin,
  // so no carry depends on a lower carry signal (true lookahead, not ripple).
  always_comb begin
    logic acc;
    logic pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < n; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      acc      = acc | (pp & cin);
      c[i + 1] = acc;
    end
  end

  assign s    = p ^ c[n-1:0];
  assign cout = c[n];

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle W-bit adder sequencing one N-bit CLA slice
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake; accepted only in IDLE
//   a, b, cin           : W-bit operands and carry-in
//   sub                 : subtract select, present only with CLA_SEQ_ADDER_SUB_EN
//   out_valid/out_ready : result handshake; result held while out_ready=0
//   sum, cout           : W-bit result and carry out of bit W-1
//   busy                : high in RUN or DONE
//   Optional feature macro: CLA_SEQ_ADDER_SUB_EN
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef CLA_SEQ_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int CHUNKS = chunks_f(W, N);
  localparam int IDX_W  = idx_w_f(W, N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  if (N < 1 || W < N || (W % N) != 0) begin : g_bad_params
    $error("cla_seq_adder: W must be a positive multiple of N");
  end

  state_e         state_q, state_d;
  logic [W-1:0]   a_sr_q, a_sr_d;
  logic [W-1:0]   b_sr_q, b_sr_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // Separate result registers keep sum/cout stable outside DONE while
  // sum_q is being refilled by the next operation.
  logic [W-1:0]   res_q, res_d;
  logic           res_cout_q, res_cout_d;

  logic [N-1:0]   slice_s;
  logic           slice_cout;

  cla_nbits #(
    .n(N)
  ) u_slice (
    .a   (a_sr_q[N-1:0]),
    .b   (b_sr_q[N-1:0]),
    .cin (carry_q),
    .s   (slice_s),
    .cout(slice_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    res_d      = res_q;
    res_cout_d = res_cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d = a;
`ifdef CLA_SEQ_ADDER_SUB_EN
          // a - b == a + ~b + 1; the forced carry replaces cin.
          b_sr_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_sr_d  = b;
          carry_d = cin;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = slice_cout;
        // Chunk results enter from the top so chunk 0 ends at the LSBs.
        sum_d   = (sum_q >> N) | (W'(slice_s) << (W - N));
        a_sr_d  = a_sr_q >> N;
        b_sr_d  = b_sr_q >> N;
        if (idx_q == LAST_IDX) begin
          state_d    = DONE;
          res_d      = sum_d;
          res_cout_d = slice_cout;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      res_q      <= '0;
      res_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      res_q      <= res_d;
      res_cout_q <= res_cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = res_q;
  assign cout      = res_cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - self-checking bench for cla_seq_adder (W=16/N=4 and W=4/N=4)
module tb_cla_seq_adder;

  localparam int W      = 16;
  localparam int N      = 4;
  localparam int CHUNKS = W / N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, cin_i, sub_i;
  logic [W-1:0]  a_i, b_i, sum_o;
  logic          out_valid, out_ready, cout_o, busy_o;

  logic          in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, busy2;
  logic [3:0]    a2, b2, sum2;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_seq_adder #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .cin(cin_i),
`ifdef CLA_SEQ_ADDER_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum_o), .cout(cout_o),
    .busy(busy_o)
  );

  cla_seq_adder #(.N(4), .W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2),
`ifdef CLA_SEQ_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2),
    .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding operation, result = a + b + cin
  // (or a + ~b + 1 for subtract) as a W+1 bit number, visible CHUNKS edges
  // after the accepting edge and held until the consumer takes it.
  bit            m_pend = 1'b0;
  int            m_acc  = 0;
  logic [W:0]    m_exp  = '0;
  logic [W:0]    m_last = '0;

  always @(negedge clk) begin
    bit exp_ov;
    if (!rst_n) begin
      m_pend = 1'b0;
      m_last = '0;
    end
    exp_ov = m_pend && (cyc >= m_acc + CHUNKS);
    chk("model out_valid", out_valid, exp_ov);
    chk("model in_ready", in_ready, !m_pend);
    chk("model busy", busy_o, m_pend);
    if (exp_ov) begin
      chk("model sum", sum_o, m_exp[W-1:0]);
      chk("model cout", cout_o, m_exp[W]);
    end else begin
      chk("model held sum", sum_o, m_last[W-1:0]);
      chk("model held cout", cout_o, m_last[W]);
    end
    if (rst_n) begin
      if (exp_ov && out_ready) begin
        m_pend = 1'b0;
        m_last = m_exp;
      end else if (!m_pend && in_valid) begin
        m_pend = 1'b1;
        m_acc  = cyc + 1;
        if (sub_i) m_exp = {1'b0, a_i} + {1'b0, ~b_i} + 1;
        else       m_exp = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
      end
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic c, input logic s);
    @(posedge clk); #1;
    a_i = av; b_i = bv; cin_i = c; sub_i = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) chk("wait out_valid timeout", out_valid, 1'b1);
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input logic s,
                         input logic [W-1:0] es, input logic ec);
    int n;
    send(av, bv, c, s);
    wait_res(n);
    chk({name, " latency"}, n, CHUNKS + 1);
    chk({name, " sum"}, sum_o, es);
    chk({name, " cout"}, cout_o, ec);
  endtask

  initial begin
    int n;
    in_valid = 0; a_i = '0; b_i = '0; cin_i = 0; sub_i = 0; out_ready = 1;
    in_valid2 = 0; a2 = '0; b2 = '0; cin2 = 0; out_ready2 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset sum", sum_o, 16'h0000);
    chk("reset cout", cout_o, 1'b0);
    chk("reset busy", busy_o, 1'b0);
    rst_n = 1'b1;

    run_vec("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_vec("add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_vec("add FFFF+FFFF+1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    run_vec("add 8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_vec("add 0FFF+0001", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0);

    // Single-chunk instance: one RUN cycle then DONE.
    @(posedge clk); #1;
    a2 = 4'hF; b2 = 4'h1; cin2 = 0; in_valid2 = 1;
    @(posedge clk); #1;
    in_valid2 = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid2 && n < 20);
    chk("w4 latency", n, 2);
    chk("w4 sum", sum2, 4'h0);
    chk("w4 cout", cout2, 1'b1);

    // Back-pressure in DONE with new operands pulsed on the input.
    out_ready = 1'b0;
    send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    wait_res(n);
    chk("bp sum", sum_o, 16'h1011);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0);
      a_i = 16'(i * 16'h1111);
      b_i = 16'h0F00;
      @(negedge clk);
      chk("bp in_ready", in_ready, 1'b0);
      chk("bp out_valid", out_valid, 1'b1);
      chk("bp held sum", sum_o, 16'h1011);
      chk("bp held cout", cout_o, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", in_ready, 1'b1);
    chk("bp release sum", sum_o, 16'h1011);

    // Reset after two RUN cycles aborts the operation.
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort sum", sum_o, 16'h0000);
    chk("abort in_ready", in_ready, 1'b1);
    chk("abort busy", busy_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("abort no result", out_valid, 1'b0);
    end
    run_vec("add 0010+0020", 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0);

`ifdef CLA_SEQ_ADDER_SUB_EN
    run_vec("sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_vec("sub 7-5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    run_vec("sub=0 add", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
